// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA 640x480@60 timing constants, board grid dimensions and
// the colour constants used by the downstream colour driver.
// Optional feature macro used by vga_timing_gen: VGA_TIMING_CELL_EN.
package vga_pkg;

    // Pixel clock divider: system clock cycles per pixel
    localparam int unsigned VGA_CLK_DIV   = 4;

    // Horizontal segments in pixels
    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;

    // Vertical segments in lines
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    // Board cell size and grid
    localparam int unsigned VGA_CELL_W    = 80;
    localparam int unsigned VGA_CELL_H    = 60;
    localparam int unsigned VGA_GRID_W    = 8;
    localparam int unsigned VGA_GRID_H    = 8;

    // Output widths
    localparam int unsigned VGA_POS_W      = 10;
    localparam int unsigned VGA_CELL_IDX_W = 3;
    localparam int unsigned VGA_OFF_X_W    = 7;
    localparam int unsigned VGA_OFF_Y_W    = 6;

    // Sum of the four segments of one axis
    function automatic int unsigned seg_total(input int unsigned vis,
                                              input int unsigned front,
                                              input int unsigned sync,
                                              input int unsigned back);
        return vis + front + sync + back;
    endfunction

    localparam int unsigned VGA_H_TOTAL      = seg_total(VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
    localparam int unsigned VGA_V_TOTAL      = seg_total(VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);
    // Sync windows are [START, END)
    localparam int unsigned VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    // 12-bit colour shared with the driver
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vga_rgb_t;

    localparam vga_rgb_t VGA_BLACK      = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam vga_rgb_t VGA_WHITE      = '{r: 4'hF, g: 4'hF, b: 4'hF};
    localparam vga_rgb_t VGA_CELL_LIGHT = '{r: 4'hE, g: 4'hD, b: 4'hB};
    localparam vga_rgb_t VGA_CELL_DARK  = '{r: 4'h8, g: 4'h5, b: 4'h3};

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   en_i           advance by one position this cycle
//   pos_o          registered position presented to the driver (resets to 0)
//   nxt_c_o        combinational value the position takes on this edge
//   sync_n_o       registered active-low sync, low for positions in [SYNC_START, SYNC_END)
//   wrap_c_o       combinational, high when en_i and the counter wraps to 0
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL      = VGA_H_TOTAL,
    parameter int unsigned SYNC_START = VGA_H_SYNC_START,
    parameter int unsigned SYNC_END   = VGA_H_SYNC_END,
    parameter int unsigned W          = VGA_POS_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] pos_o,
    output logic [W-1:0] nxt_c_o,
    output logic         sync_n_o,
    output logic         wrap_c_o
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] pos_q;
    logic         sync_n_q, sync_n_d;
    logic         wrap_c;

    // Next count and sync level
    always_comb begin
        wrap_c   = en_i && (cnt_q == LAST);
        cnt_d    = cnt_q;
        if (en_i) begin
            cnt_d = wrap_c ? '0 : cnt_q + W'(1);
        end
        sync_n_d = !((cnt_d >= W'(SYNC_START)) && (cnt_d < W'(SYNC_END)));
    end

    // Internal counter starts at the last position so the first advance lands on 0,
    // while the presented position resets to 0 independently.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= LAST;
            pos_q    <= '0;
            sync_n_q <= 1'b1;
        end else if (en_i) begin
            cnt_q    <= cnt_d;
            pos_q    <= cnt_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign pos_o    = pos_q;
    assign nxt_c_o  = cnt_d;
    assign sync_n_o = sync_n_q;
    assign wrap_c_o = wrap_c;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing from the 100 MHz system clock.
// Optional macro VGA_TIMING_CELL_EN builds the incremental board cell/offset
// counters; without it cell_x/cell_y/offset_x/offset_y are tied to 0.
// Ports:
//   clk_in, rst_n          system clock, async active-low reset
//   pixel_tick             high for the first clk_in cycle of every pixel
//   current_row/line       horizontal 0..H_TOTAL-1 / vertical 0..V_TOTAL-1
//   enable                 visible-area flag
//   hsync, vsync           active-low sync
//   frame_start            one-cycle pulse with the (0,0) pixel
//   cell_x/y, offset_x/y   board cell under the beam and position inside it
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK
`ifdef VGA_TIMING_CELL_EN
   ,parameter int unsigned CELL_W    = VGA_CELL_W,
    parameter int unsigned CELL_H    = VGA_CELL_H
`endif
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    output logic                      pixel_tick,
    output logic [VGA_POS_W-1:0]      current_row,
    output logic [VGA_POS_W-1:0]      current_line,
    output logic                      enable,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      frame_start,
    output logic [VGA_CELL_IDX_W-1:0] cell_x,
    output logic [VGA_CELL_IDX_W-1:0] cell_y,
    output logic [VGA_OFF_X_W-1:0]    offset_x,
    output logic [VGA_OFF_Y_W-1:0]    offset_y
);

    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL = seg_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = seg_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    logic [DIV_W-1:0]     div_q, div_d;
    logic                 adv_c;
    logic                 pixel_tick_q;
    logic                 frame_start_q;
    logic                 enable_q, enable_d;
    logic [VGA_POS_W-1:0] h_nxt, v_nxt;
    logic                 h_wrap, v_wrap;

    // Pixel clock divider; adv_c marks the edge on which the beam advances
    always_comb begin
        adv_c = (div_q == DIV_W'(CLK_DIV - 1));
        div_d = adv_c ? '0 : div_q + DIV_W'(1);
    end

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC),
        .W          (VGA_POS_W)
    ) u_h_axis (
        .clk_i    (clk_in),
        .rst_ni   (rst_n),
        .en_i     (adv_c),
        .pos_o    (current_row),
        .nxt_c_o  (h_nxt),
        .sync_n_o (hsync),
        .wrap_c_o (h_wrap)
    );

    // Vertical axis steps only on the horizontal wrap
    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC),
        .W          (VGA_POS_W)
    ) u_v_axis (
        .clk_i    (clk_in),
        .rst_ni   (rst_n),
        .en_i     (h_wrap),
        .pos_o    (current_line),
        .nxt_c_o  (v_nxt),
        .sync_n_o (vsync),
        .wrap_c_o (v_wrap)
    );

    // Visible-area flag for the position being loaded
    always_comb begin
        enable_d = (h_nxt < VGA_POS_W'(H_VISIBLE)) && (v_nxt < VGA_POS_W'(V_VISIBLE));
    end

    // Strobes and enable; v_wrap already implies an advance with a line wrap
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            pixel_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
            enable_q      <= 1'b0;
        end else begin
            div_q         <= div_d;
            pixel_tick_q  <= adv_c;
            frame_start_q <= v_wrap;
            if (adv_c) begin
                enable_q <= enable_d;
            end
        end
    end

    assign pixel_tick  = pixel_tick_q;
    assign frame_start = frame_start_q;
    assign enable      = enable_q;

`ifdef VGA_TIMING_CELL_EN
    logic [VGA_CELL_IDX_W-1:0] cell_x_q, cell_x_d, cell_y_q, cell_y_d;
    logic [VGA_OFF_X_W-1:0]    off_x_q, off_x_d;
    logic [VGA_OFF_Y_W-1:0]    off_y_q, off_y_d;

    // Cells step only while the position being loaded is still visible, so they
    // freeze at the last cell/offset through blanking and clear on the axis wrap.
    always_comb begin
        cell_x_d = cell_x_q;
        off_x_d  = off_x_q;
        cell_y_d = cell_y_q;
        off_y_d  = off_y_q;

        if (h_wrap) begin
            cell_x_d = '0;
            off_x_d  = '0;
        end else if (adv_c && (h_nxt < VGA_POS_W'(H_VISIBLE))) begin
            if (off_x_q == VGA_OFF_X_W'(CELL_W - 1)) begin
                off_x_d  = '0;
                cell_x_d = cell_x_q + VGA_CELL_IDX_W'(1);
            end else begin
                off_x_d  = off_x_q + VGA_OFF_X_W'(1);
            end
        end

        if (v_wrap) begin
            cell_y_d = '0;
            off_y_d  = '0;
        end else if (h_wrap && (v_nxt < VGA_POS_W'(V_VISIBLE))) begin
            if (off_y_q == VGA_OFF_Y_W'(CELL_H - 1)) begin
                off_y_d  = '0;
                cell_y_d = cell_y_q + VGA_CELL_IDX_W'(1);
            end else begin
                off_y_d  = off_y_q + VGA_OFF_Y_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cell_x_q <= '0;
            off_x_q  <= '0;
            cell_y_q <= '0;
            off_y_q  <= '0;
        end else begin
            cell_x_q <= cell_x_d;
            off_x_q  <= off_x_d;
            cell_y_q <= cell_y_d;
            off_y_q  <= off_y_d;
        end
    end

    assign cell_x   = cell_x_q;
    assign offset_x = off_x_q;
    assign cell_y   = cell_y_q;
    assign offset_y = off_y_q;
`else
    assign cell_x   = '0;
    assign offset_x = '0;
    assign cell_y   = '0;
    assign offset_y = '0;
`endif

endmodule
